uart_rx_sampler: RTL

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_os_tick.sv | 30 +++
 rtl/uart_rx_sampler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive sampler: FSM state encoding,
// word-length encoding of the DataBits control, default oversample ratio.
// No ports; imported by uart_rx_sampler.
package uart_rx_pkg;

  localparam int OSR_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } data_bits_t;

  // Number of data bits carried by a frame for a given DataBits code.
  function automatic logic [3:0] word_len(input logic [1:0] enc);
    return 4'd5 + {2'b00, enc};
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: counts 0..Divisor and strobes os_tick on wrap.
// Latency: os_tick is a combinational decode of the counter (Divisor=0 -> every clock).
// Backpressure: none; Clear restarts the count and suppresses the tick that cycle.
// Ports: Clock, ResetN (async active-low), Clear (restart), Divisor (clocks per tick - 1),
//        os_tick (one-cycle strobe).
module uart_os_tick #(
  parameter int DIV_W = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Clear,
  input  logic [DIV_W-1:0] Divisor,
  output logic             os_tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      cnt <= '0;
    end else if (Clear || (cnt == Divisor)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign os_tick = !Clear && (cnt == Divisor);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: oversampled start/data/parity/stop decoding into a one-word output register.
// Latency: RxData/RxValid/errors update one clock after the final stop decision point.
// Backpressure: RxValid holds until RxReady; a word arriving while unaccepted overwrites and sets Overrun.
// Ports: Clock, ResetN (async active-low), DataRx (async line, idle high), Divisor,
//        DataBits/ParityEn/ParityOdd/TwoStop (frame format, latched at start edge), RxReady,
//        RxData, RxValid, FrameErr, ParityErr, Overrun, SampleTick, Busy.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 voting around mid-bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int OSR   = OSR_DEFAULT
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             DataRx,
  input  logic [DIV_W-1:0] Divisor,
  input  logic [1:0]       DataBits,
  input  logic             ParityEn,
  input  logic             ParityOdd,
  input  logic             TwoStop,
  input  logic             RxReady,
  output logic [7:0]       RxData,
  output logic             RxValid,
  output logic             FrameErr,
  output logic             ParityErr,
  output logic             Overrun,
  output logic             SampleTick,
  output logic             Busy
);

  localparam int PH_W = $clog2(OSR);
  localparam int MID  = OSR / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC  = MID + 1;
`else
  localparam int DEC  = MID;
`endif
  localparam logic [PH_W-1:0] DEC_PH  = PH_W'(DEC);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OSR - 1);

  rx_state_t        state;
  logic [PH_W-1:0]  phase;
  logic [DIV_W-1:0] div_l;
  logic [1:0]       bits_l;
  logic             par_en_l, par_odd_l, two_stop_l;
  logic [7:0]       shreg;
  logic [3:0]       bit_cnt;
  logic             stop_idx;
  logic             frame_acc, par_err_acc;

  logic             sync1, rx_s, rx_prev;
  logic [1:0]       settle;
  logic             start_edge;
  logic             os_tick;
  logic             dec, wrap;
  logic             bit_val;
  logic [3:0]       len_l;
  logic [7:0]       rx_word;
  logic             last_stop, done;

  // Two-flop synchroniser plus edge-detect history. The settle counter blocks
  // start detection until the reset value (1) has flushed through all three
  // flops, so a line held low across reset release is not taken as a start.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 2'd0;
    end else begin
      sync1   <= DataRx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign start_edge = (state == ST_IDLE) && (settle == 2'd3) && rx_prev && !rx_s;

  uart_os_tick #(.DIV_W(DIV_W)) u_os_tick (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .Clear   (start_edge),
    .Divisor (div_l),
    .os_tick (os_tick)
  );

  assign dec  = os_tick && (phase == DEC_PH);
  assign wrap = os_tick && (phase == LAST_PH);

`ifdef UART_RX_MAJORITY_EN
  // Samples one tick before and at mid-bit; the third vote is the live
  // sample at the decision point one tick after mid-bit.
  logic [1:0] votes;
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      votes <= 2'b11;
    end else begin
      if (os_tick && (phase == PH_W'(MID - 1))) votes[0] <= rx_s;
      if (os_tick && (phase == PH_W'(MID)))     votes[1] <= rx_s;
    end
  end
  assign bit_val = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign len_l   = word_len(bits_l);
  // Bits shift in from the top, so a short word sits in the upper bits.
  assign rx_word = shreg >> (4'd8 - len_l);

  assign last_stop = !(two_stop_l && !stop_idx);
  assign done      = (state == ST_STOP) && dec && last_stop;
  assign Busy      = (state != ST_IDLE);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= ST_IDLE;
      phase       <= '0;
      div_l       <= '0;
      bits_l      <= 2'b00;
      par_en_l    <= 1'b0;
      par_odd_l   <= 1'b0;
      two_stop_l  <= 1'b0;
      shreg       <= 8'h00;
      bit_cnt     <= 4'd0;
      stop_idx    <= 1'b0;
      frame_acc   <= 1'b0;
      par_err_acc <= 1'b0;
      SampleTick  <= 1'b0;
    end else begin
      SampleTick <= dec && (state != ST_IDLE);

      if (start_edge) begin
        phase <= '0;
      end else if (os_tick) begin
        phase <= (phase == LAST_PH) ? '0 : phase + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            div_l       <= Divisor;
            bits_l      <= DataBits;
            par_en_l    <= ParityEn;
            par_odd_l   <= ParityOdd;
            two_stop_l  <= TwoStop;
            shreg       <= 8'h00;
            bit_cnt     <= 4'd0;
            stop_idx    <= 1'b0;
            frame_acc   <= 1'b0;
            par_err_acc <= 1'b0;
            state       <= ST_START;
          end
        end
        ST_START: begin
          if (dec && bit_val) begin
            state <= ST_IDLE;
          end else if (wrap) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (dec) begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (wrap && (bit_cnt == len_l)) begin
            state <= par_en_l ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (dec) begin
            par_err_acc <= bit_val != ((^rx_word) ^ par_odd_l);
          end else if (wrap) begin
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // The final stop decision leaves immediately so the next start
          // edge can arrive during what remains of the stop bit.
          if (dec) begin
            if (last_stop) begin
              state <= ST_IDLE;
            end else begin
              stop_idx  <= 1'b1;
              frame_acc <= frame_acc | !bit_val;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output word register; a new word takes priority over a same-cycle accept.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      RxData    <= 8'h00;
      RxValid   <= 1'b0;
      FrameErr  <= 1'b0;
      ParityErr <= 1'b0;
      Overrun   <= 1'b0;
    end else if (done) begin
      RxData    <= rx_word;
      FrameErr  <= frame_acc | !bit_val;
      ParityErr <= par_err_acc;
      Overrun   <= RxValid && !RxReady;
      RxValid   <= 1'b1;
    end else if (RxValid && RxReady) begin
      RxValid   <= 1'b0;
      Overrun   <= 1'b0;
    end
  end

endmodule
